// File: rtl/muldiv_sequencer_if.sv
// Handshake and HI/LO bus between the control unit and the iterative multiply/divide sequencer.
// The control unit drives through the master modport; the sequencer sits on the slave side.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring-subtract step per clock.
// Signed operations run on magnitudes; the sign is fixed up when the result is written.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t             state_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   mag_b_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               signed_op_s;
  logic [WIDTH-1:0]   mag_a_in_s;
  logic [WIDTH-1:0]   mag_b_in_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH+1:0]   diff_s;
  logic [WIDTH:0]     msum_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  // Operand magnitudes, one datapath step, and the sign-corrected result.
  always_comb begin
    signed_op_s = bus.op[0];
    mag_a_in_s  = (signed_op_s && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b_in_s  = (signed_op_s && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Divide: acc holds {remainder, dividend bits still to shift in / quotient bits}.
    rem_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    diff_s      = {1'b0, rem_shift_s} - {2'b00, mag_b_r};
    msum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, mag_b_r} : {(WIDTH+1){1'b0}});

    if (op_r[1]) begin
      if (!diff_s[WIDTH+1]) begin
        acc_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {rem_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = {msum_s, acc_r[WIDTH-1:1]};
    end

    prod_s = neg_res_r ? -acc_r : acc_r;
    if (op_r[1]) begin
      if (mag_b_r == {WIDTH{1'b0}}) begin
        res_hi_s = a_r;
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_hi_s = neg_rem_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
        res_lo_s = neg_res_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
      end
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Sequencer FSM with registered busy/done and HI/LO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'b00;
      a_r       <= {WIDTH{1'b0}};
      mag_b_r   <= {WIDTH{1'b0}};
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.hi_we) hi_r <= bus.wd;
          if (bus.lo_we) lo_r <= bus.wd;
          if (bus.start && !bus.abort) begin
            op_r      <= bus.op;
            a_r       <= bus.a;
            mag_b_r   <= mag_b_in_s;
            neg_res_r <= signed_op_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_r <= signed_op_s && bus.a[WIDTH-1];
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {{WIDTH{1'b0}}, mag_a_in_s};
            busy_r    <= 1'b1;
            state_r   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (bus.abort) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == LAST_STEP) state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
          if (!bus.abort) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected HI/LO pairs are queued at launch and
// a monitor checks them whenever done pulses; latency, abort, reset and MT writes are checked inline.
module tb_muldiv_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  muldiv_sequencer #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(negedge clock) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no result", bus.hi, bus.lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", {32'h0, bus.hi}, {32'h0, e[63:32]});
        check("result_lo", {32'h0, bus.lo}, {32'h0, e[31:0]});
      end
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [31:0] eh, input logic [31:0] el);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    if (push) begin
      exp_q.push_back({eh, el});
      model_hi = eh;
      model_lo = el;
    end
    @(negedge clock);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  task automatic wait_done(input int expected_busy);
    int cyc = 0;
    while (bus.busy && cyc < 200) begin
      cyc++;
      @(negedge clock);
    end
    check("busy_cycles", 64'(cyc), 64'(expected_busy));
    check("done_high", {63'h0, bus.done}, 64'h1);
    @(negedge clock);
    check("done_width", {63'h0, bus.done}, 64'h0);
    check("busy_after", {63'h0, bus.busy}, 64'h0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    launch(op, a, b, 1'b1, eh, el);
    wait_done(33);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'h0; bus.b = 32'h0;
    bus.abort = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = 32'h0;
    model_hi = 32'h0; model_lo = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_hi",   {32'h0, bus.hi}, 64'h0);
    check("reset_lo",   {32'h0, bus.lo}, 64'h0);
    check("reset_busy", {63'h0, bus.busy}, 64'h0);
    check("reset_done", {63'h0, bus.done}, 64'h0);

    // MT writes while idle
    bus.hi_we = 1'b1; bus.wd = 32'h1111_1111;
    @(negedge clock);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wd = 32'h2222_2222;
    @(negedge clock);
    bus.lo_we = 1'b0;
    check("mthi_idle", {32'h0, bus.hi}, 64'h1111_1111);
    check("mtlo_idle", {32'h0, bus.lo}, 64'h2222_2222);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op(2'b10, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Abort at E10: no done, HI/LO keep their previous values
    launch(2'b00, 32'd5, 32'd6, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("abort_busy", {63'h0, bus.busy}, 64'h0);
    check("abort_hi", {32'h0, bus.hi}, {32'h0, model_hi});
    check("abort_lo", {32'h0, bus.lo}, {32'h0, model_lo});
    repeat (40) @(negedge clock);
    check("abort_hi_later", {32'h0, bus.hi}, {32'h0, model_hi});
    check("abort_lo_later", {32'h0, bus.lo}, {32'h0, model_lo});

    // Second start at E3 of a running DIVU is ignored
    launch(2'b10, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    repeat (2) @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done(30);

    // MTHI while busy is dropped; MTHI while idle lands
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    bus.hi_we = 1'b1; bus.wd = 32'hA5A5_A5A5;
    @(negedge clock);
    bus.hi_we = 1'b0;
    check("mthi_busy", {32'h0, bus.hi}, 64'h0000_0000_0000_0002);
    wait_done(32);
    bus.hi_we = 1'b1;
    @(negedge clock);
    bus.hi_we = 1'b0;
    check("mthi_after", {32'h0, bus.hi}, 64'hA5A5_A5A5);

    // MT write together with start: write lands at E0, result overwrites later
    bus.hi_we = 1'b1; bus.wd = 32'hDEAD_BEEF;
    launch(2'b00, 32'd5, 32'd6, 1'b1, 32'h0, 32'd30);
    check("mthi_with_start", {32'h0, bus.hi}, 64'hDEAD_BEEF);
    wait_done(33);

    // Async reset at E20 of a DIV
    launch(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'h0, 32'h0);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mid_hi",   {32'h0, bus.hi}, 64'h0);
    check("rst_mid_lo",   {32'h0, bus.lo}, 64'h0);
    check("rst_mid_busy", {63'h0, bus.busy}, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("rst_mid_no_done", {63'h0, bus.busy}, 64'h0);

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
